// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one-entry buffer, pending redirect and optional perf counters (FETCH_PERF_EN).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_memory,
  input  logic        en_branch,
  input  logic        en_fetch,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        branch,
  output logic        done,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic [15:0] fetch_cnt,
  output logic [15:0] redirect_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, HAVE, DROP} state_t;
  state_t state, state_n;
  logic pending, take, commit, bad;
  logic [31:0] target, buffer, addr;
  assign take = en_branch && pending;
  assign commit = en_fetch && !branch && !take && state == HAVE;
  assign bad = en_fetch && !branch && !take && state != HAVE;
  assign mem_req = state == REQ || state == DROP;
  assign mem_addr = addr;
  assign done = state == HAVE;
  // A redirect during an outstanding read must still wait out its ack before reusing the bus.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = en_memory && !take ? REQ : IDLE;
      REQ:     state_n = take ? (mem_ack ? IDLE : DROP) : (mem_ack ? HAVE : REQ);
      HAVE:    state_n = take || commit ? IDLE : HAVE;
      DROP:    state_n = mem_ack ? IDLE : DROP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= '0;
      branch <= 1'b0;
      fetch_err <= 1'b0;
      pending <= 1'b0;
      target <= '0;
      buffer <= '0;
      addr <= '0;
    end else begin
      state <= state_n;
      branch <= take;
      fetch_err <= fetch_err | bad;
      pending <= br_valid | (pending & ~take);
      if (br_valid) target <= br_target;
      if (state == IDLE && en_memory && !take) addr <= pc;
      if (state == REQ && mem_ack) buffer <= mem_rdata;
      if (commit) begin
        instr <= buffer;
        pc <= pc + 32'd4;
      end
      if (take) pc <= target;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= '0;
      redirect_cnt <= '0;
    end else begin
      if (commit && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
      if (take && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`else
  assign fetch_cnt = '0;
  assign redirect_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus, per-cycle comparison against a transaction-level model, plus literal anchors.
module tb_fetch_unit;
  logic clk = 0, reset = 1;
  logic en_memory = 0, en_branch = 0, en_fetch = 0, br_valid = 0, mem_ack = 0;
  logic [31:0] br_target = 0, mem_rdata = 0;
  logic mem_req, branch, done, fetch_err;
  logic [31:0] mem_addr, instr, pc;
  logic [15:0] fetch_cnt, redirect_cnt;
  int checks = 0, errors = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .en_memory(en_memory), .en_branch(en_branch), .en_fetch(en_fetch),
    .br_valid(br_valid), .br_target(br_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .branch(branch), .done(done), .instr(instr),
    .pc(pc), .fetch_err(fetch_err), .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model phases: 0 no read, 1 awaiting data, 2 instruction buffered, 3 awaiting ack to discard.
  int m_ph;
  bit m_init = 0, m_pend, m_br, m_err;
  logic [31:0] m_pc, m_instr, m_buf, m_tgt, m_addr;
  int m_fc, m_rc;
  always @(posedge clk) begin
    if (reset) begin
      m_init = 1; m_ph = 0; m_pc = 0; m_instr = 0; m_err = 0; m_pend = 0; m_br = 0;
      m_fc = 0; m_rc = 0;
    end else begin
      automatic int ph = m_ph;
      automatic bit take = en_branch && m_pend;
      automatic bit fetch = en_fetch && !m_br && !take;
      if (fetch && ph == 2) begin
        m_instr = m_buf; m_pc = m_pc + 4; m_ph = 0;
        if (m_fc < 65535) m_fc++;
      end
      if (fetch && ph != 2) m_err = 1;
      if (ph == 0 && en_memory && !take) begin m_ph = 1; m_addr = m_pc; end
      if (ph == 1 && mem_ack) begin m_ph = 2; m_buf = mem_rdata; end
      if (ph == 3 && mem_ack) m_ph = 0;
      if (take) begin
        m_ph = ((ph == 1 || ph == 3) && !mem_ack) ? 3 : 0;
        m_pc = m_tgt;
        if (m_rc < 65535) m_rc++;
      end
      m_br = take;
      if (br_valid) begin m_pend = 1; m_tgt = br_target; end
      else if (take) m_pend = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("mem_req", {31'd0, mem_req}, {31'd0, m_ph == 1 || m_ph == 3});
      if (m_ph == 1 || m_ph == 3) check("mem_addr", mem_addr, m_addr);
      check("done", {31'd0, done}, {31'd0, m_ph == 2});
      check("branch", {31'd0, branch}, {31'd0, m_br});
      check("pc", pc, m_pc);
      check("instr", instr, m_instr);
      check("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
`ifdef FETCH_PERF_EN
      check("fetch_cnt", {16'd0, fetch_cnt}, m_fc);
      check("redirect_cnt", {16'd0, redirect_cnt}, m_rc);
`else
      check("fetch_cnt", {16'd0, fetch_cnt}, 0);
      check("redirect_cnt", {16'd0, redirect_cnt}, 0);
`endif
    end
  end

  task automatic cyc(input logic em = 0, input logic eb = 0, input logic ef = 0, input logic bv = 0,
                     input logic [31:0] bt = 0, input logic ack = 0, input logic [31:0] rd = 0);
    en_memory = em; en_branch = eb; en_fetch = ef; br_valid = bv; br_target = bt;
    mem_ack = ack; mem_rdata = rd;
    @(posedge clk);
    #1;
    en_memory = 0; en_branch = 0; en_fetch = 0; br_valid = 0; mem_ack = 0;
  endtask

  task automatic redirect(input logic [31:0] t);
    cyc(.bv(1), .bt(t));
    cyc(.eb(1));
  endtask

  task automatic fetch_one(input logic [31:0] d);
    cyc(.em(1));
    cyc(.ack(1), .rd(d));
    cyc(.ef(1));
  endtask

  initial begin
    cyc(); cyc();
    reset = 0;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    // Basic fetch with ack two cycles after the request.
    cyc(.em(1));
    check("req_addr", {mem_addr[31:1], mem_req}, 32'h1);
    cyc();
    cyc(.ack(1), .rd(32'h0050_0093));
    check("done_set", {31'd0, done}, 32'd1);
    cyc(.ef(1));
    check("f1_instr", instr, 32'h0050_0093);
    check("f1_pc", pc, 32'h4);
    check("f1_done", {31'd0, done}, 32'd0);
    // Redirect then fetch from target.
    redirect(32'h100);
    check("br_pulse", {31'd0, branch}, 32'd1);
    check("br_pc", pc, 32'h100);
    cyc();
    check("br_end", {31'd0, branch}, 32'd0);
    cyc(.em(1));
    check("br_addr", mem_addr, 32'h100);
    cyc(.ack(1), .rd(32'h13));
    cyc(.ef(1));
    // Redirect while a read is outstanding drops that read's data.
    cyc(.bv(1), .bt(32'h200));
    cyc(.em(1));
    cyc(.eb(1));
    check("drop_req", {31'd0, mem_req}, 32'd1);
    cyc(); cyc();
    cyc(.ack(1), .rd(32'hDEAD_BEEF));
    check("drop_instr", instr, 32'h13);
    check("drop_idle", {30'd0, mem_req, done}, 32'd0);
    cyc(.em(1));
    check("drop_addr", mem_addr, 32'h200);
    cyc(.ack(1), .rd(32'h11));
    cyc(.ef(1));
    check("drop_pc", pc, 32'h204);
    // en_fetch during the branch cycle is ignored (no error).
    redirect(32'h300);
    cyc(.ef(1));
    check("ign_err", {31'd0, fetch_err}, 32'd0);
    // en_fetch with an empty buffer flags a sticky error.
    cyc(.ef(1));
    cyc(); cyc();
    check("err_sticky", {31'd0, fetch_err}, 32'd1);
    check("err_pc", pc, 32'h300);
    // br_valid coinciding with a consuming en_branch re-arms the pending target.
    cyc(.bv(1), .bt(32'h400));
    cyc(.eb(1), .bv(1), .bt(32'h500));
    check("rearm_pc1", pc, 32'h400);
    cyc(.eb(1));
    check("rearm_pc2", pc, 32'h500);
    // PC wraps past the top of the address space.
    redirect(32'hFFFF_FFFC);
    fetch_one(32'h22);
    check("wrap_pc", pc, 32'h0);
    // en_branch with nothing pending does nothing.
    cyc(.eb(1));
    check("nopend_br", {31'd0, branch}, 32'd0);
    // Reset mid-request; a late ack is ignored.
    cyc(.em(1));
    reset = 1;
    cyc();
    reset = 0;
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    cyc(.ack(1), .rd(32'h77));
    check("late_ack", {31'd0, done}, 32'd0);
    // Counters: three fetches and one redirect.
    for (int i = 0; i < 3; i++) fetch_one(32'h100 + i);
    redirect(32'h40);
    cyc();
    check("cnt_pc", pc, 32'h40);
    check("cnt_instr", instr, 32'h102);
`ifdef FETCH_PERF_EN
    check("fetch_cnt3", {16'd0, fetch_cnt}, 32'd3);
    check("redir_cnt1", {16'd0, redirect_cnt}, 32'd1);
`else
    check("fetch_cnt0", {16'd0, fetch_cnt}, 32'd0);
    check("redir_cnt0", {16'd0, redirect_cnt}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000, as the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port en_memory, input, 1, a one-cycle pulse from the top sequencer that starts an instruction-memory read.
REQ-005 The block SHALL have port en_branch, input, 1, a one-cycle pulse that evaluates a pending redirect.
REQ-006 The block SHALL have port en_fetch, input, 1, a one-cycle pulse that commits the buffered instruction.
REQ-007 The block SHALL have port br_valid, input, 1, a redirect request from execute; br_target, input, 32, its target address.
REQ-008 The block SHALL have port mem_req, output, 1, and mem_addr, output, 32, forming the read request.
REQ-009 The block SHALL have port mem_ack, input, 1, and mem_rdata, input, 32, forming the read response.
REQ-010 The block SHALL have port branch, output, 1, the redirect-taken flag; done, output, 1, meaning the instruction buffer is full.
REQ-011 The block SHALL have port instr, output, 32, and pc, output, 32, giving the committed instruction and the current PC.
REQ-012 The block SHALL have port fetch_err, output, 1, a sticky error flag; fetch_cnt, output, 16, and redirect_cnt, output, 16, as performance counters.

Function
REQ-013 The read FSM SHALL have states IDLE, REQ, and HAVE: IDLE goes to REQ on en_memory; REQ goes to HAVE on mem_ack; HAVE goes to IDLE on a committing en_fetch or a taken redirect.
REQ-014 mem_req SHALL be 1 exactly while in REQ, with mem_addr equal to pc held stable until mem_ack.
REQ-015 On mem_ack in REQ, mem_rdata SHALL be captured into the buffer; done SHALL be 1 from the next cycle while in HAVE.
REQ-016 en_memory outside IDLE SHALL be ignored.
REQ-017 br_valid SHALL latch br_target and set a pending flag; a later br_valid overwrites it (last wins).
REQ-018 en_branch with pending=1 SHALL, at that edge:
  - set branch=1 for exactly the next cycle;
  - load pc with the latched target;
  - clear pending;
  - empty the buffer (FSM goes to IDLE).
REQ-019 en_branch with pending=0 SHALL hold branch=0 and change no state.
REQ-020 br_valid in the same cycle as a consuming en_branch SHALL leave pending=1 with the new target.
REQ-021 A taken redirect while in REQ SHALL move the FSM to a drop sub-state that keeps mem_req=1 until mem_ack, discards the data, then returns to IDLE.
REQ-022 en_fetch while branch=1 SHALL be ignored.
REQ-023 Otherwise, en_fetch in HAVE SHALL load instr from the buffer, set pc to pc+4 (mod 2^32, wrapping at 0xFFFF_FFFC), and return to IDLE.
REQ-024 en_fetch outside HAVE SHALL set fetch_err=1 (sticky until reset) and leave instr and pc unchanged.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL enter IDLE with pc=RESET_PC and instr=0.
REQ-026 At that same edge, mem_req, branch, done, fetch_err, pending, the counters, and the drop flag SHALL all be 0.
REQ-027 Reset SHALL override all inputs, including mid-request; a mem_ack arriving after reset SHALL be ignored.

Configuration
REQ-028 With macro FETCH_PERF_EN defined:
  - fetch_cnt SHALL increment on each committing en_fetch;
  - redirect_cnt SHALL increment on each taken redirect;
  - both counters SHALL saturate at 0xFFFF.
REQ-029 With FETCH_PERF_EN undefined, fetch_cnt and redirect_cnt SHALL be constant 0, with no counter flops and the ports still present.

Verification
REQ-030 Reset, en_memory, mem_ack two cycles later with rdata=0x00500093, then en_fetch -> mem_addr=0x0 during REQ; instr=0x00500093; pc=0x4; done back to 0.
REQ-031 br_valid with target 0x100, then en_branch -> branch=1 for one cycle; pc=0x100; the next en_memory drives mem_addr=0x100.
REQ-032 Redirect taken during REQ, with mem_ack arriving 3 cycles later with data 0xDEADBEEF -> instr unchanged; FSM in IDLE; a following fetch reads from the target.
REQ-033 en_fetch with no prior en_memory -> fetch_err=1 persists; pc unchanged; only reset clears it.
REQ-034 pc=0xFFFF_FFFC, then a full fetch -> pc=0x0.
REQ-035 With FETCH_PERF_EN defined, 3 fetches and 1 redirect -> fetch_cnt=3 and redirect_cnt=1; with the macro undefined, both read 0.
